mult_error_sweep: RTL and testbench



---
 rtl/mult_error_sweep_pkg.sv | 26 ++
 rtl/mult_error_sweep_accum.sv | 65 ++++++
 rtl/mult_error_sweep.sv | 121 ++++++++++++
 tb/tb_mult_error_sweep.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_error_sweep_pkg.sv
// Shared definitions for the exhaustive multiplier error sweep:
// FSM state encoding, default operand width and derived result widths.
package mult_error_sweep_pkg;

    localparam int unsigned OPW_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic int unsigned prod_w(input int unsigned opw);
        return 2 * opw;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned opw);
        return 2 * opw + 1;
    endfunction

    function automatic int unsigned sum_w(input int unsigned opw);
        return 4 * opw;
    endfunction

endpackage

// File: rtl/mult_error_sweep_accum.sv
// Stage 2 of the sweep: absolute error of one operand pair folded into
// the error count, error sum and first-occurrence maximum.
module mult_error_accum
    import mult_error_sweep_pkg::*;
#(
    parameter int unsigned OPW = OPW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic [prod_w(OPW)-1:0]  i_prod,
    input  logic [prod_w(OPW)-1:0]  i_exact,
    input  logic [OPW-1:0]          i_a,
    input  logic [OPW-1:0]          i_b,
    output logic [cnt_w(OPW)-1:0]   o_err_count,
    output logic [sum_w(OPW)-1:0]   o_err_sum,
    output logic [prod_w(OPW)-1:0]  o_max_err,
    output logic [OPW-1:0]          o_max_a,
    output logic [OPW-1:0]          o_max_b
);

    localparam int unsigned PW = prod_w(OPW);
    localparam int unsigned CW = cnt_w(OPW);
    localparam int unsigned SW = sum_w(OPW);

    logic [PW-1:0] w_diff;
    logic [CW-1:0] r_err_count;
    logic [SW-1:0] r_err_sum;
    logic [PW-1:0] r_max_err;
    logic [OPW-1:0] r_max_a;
    logic [OPW-1:0] r_max_b;

    always_comb begin
        w_diff = (i_prod >= i_exact) ? (i_prod - i_exact) : (i_exact - i_prod);
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_err_count <= '0;
            r_err_sum   <= '0;
            r_max_err   <= '0;
            r_max_a     <= '0;
            r_max_b     <= '0;
        end else if (i_valid) begin
            if (w_diff != '0) begin
                r_err_count <= r_err_count + CW'(1);
            end
            r_err_sum <= r_err_sum + SW'(w_diff);
            // strict compare keeps the earliest pair on ties
            if (w_diff > r_max_err) begin
                r_max_err <= w_diff;
                r_max_a   <= i_a;
                r_max_b   <= i_b;
            end
        end
    end

    assign o_err_count = r_err_count;
    assign o_err_sum   = r_err_sum;
    assign o_max_err   = r_max_err;
    assign o_max_a     = r_max_a;
    assign o_max_b     = r_max_b;

endmodule

// File: rtl/mult_error_sweep.sv
// Drives every operand pair into an external multiplier and measures its
// error against the exact product through a two-stage pipeline.
module mult_error_sweep
    import mult_error_sweep_pkg::*;
#(
    parameter int unsigned OPW = OPW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [OPW-1:0]          mult_a,
    output logic [OPW-1:0]          mult_b,
    input  logic [prod_w(OPW)-1:0]  mult_p,
    output logic                    busy,
    output logic                    done,
    output logic [cnt_w(OPW)-1:0]   err_count,
    output logic [sum_w(OPW)-1:0]   err_sum,
    output logic [prod_w(OPW)-1:0]  max_err,
    output logic [OPW-1:0]          max_a,
    output logic [OPW-1:0]          max_b
);

    localparam int unsigned PW = prod_w(OPW);

    state_t         r_state;
    logic [OPW-1:0] r_a;
    logic [OPW-1:0] r_b;
    logic           r_drain;
    logic           r_busy;
    logic           r_done;

    logic           r_s1_valid;
    logic [PW-1:0]  r_s1_prod;
    logic [PW-1:0]  r_s1_exact;
    logic [OPW-1:0] r_s1_a;
    logic [OPW-1:0] r_s1_b;

    logic           w_launch;

    assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_SWEEP;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    // last pair is held rather than wrapped so operands keep it afterwards
                    if ((r_a == '1) && (r_b == '1)) begin
                        r_state <= S_DRAIN;
                        r_drain <= 1'b0;
                    end else begin
                        r_a <= r_a + 1'b1;
                        if (r_a == '1) begin
                            r_b <= r_b + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_launch) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= (r_state == S_SWEEP);
        end
        if (r_state == S_SWEEP) begin
            r_s1_prod  <= mult_p;
            r_s1_exact <= PW'(r_a) * PW'(r_b);
            r_s1_a     <= r_a;
            r_s1_b     <= r_b;
        end
    end

    mult_error_accum #(.OPW(OPW)) u_accum (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_launch),
        .i_valid     (r_s1_valid),
        .i_prod      (r_s1_prod),
        .i_exact     (r_s1_exact),
        .i_a         (r_s1_a),
        .i_b         (r_s1_b),
        .o_err_count (err_count),
        .o_err_sum   (err_sum),
        .o_max_err   (max_err),
        .o_max_a     (max_a),
        .o_max_b     (max_b)
    );

    assign mult_a = r_a;
    assign mult_b = r_b;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_mult_error_sweep.sv
// Self-checking bench: stub multipliers with known error patterns plus a
// randomly corrupted product table, checked against exhaustive expected sums.
module tb_mult_error_sweep;

    localparam int unsigned OPW    = 6;
    localparam int unsigned PW     = 2 * OPW;
    localparam int unsigned NP     = 1 << PW;
    localparam int unsigned NOP    = 1 << OPW;
    localparam int unsigned N_DONE = NP + 2;
    localparam int unsigned BAD_A  = 50;
    localparam int unsigned BAD_B  = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [OPW-1:0]    mult_a;
    logic [OPW-1:0]    mult_b;
    logic [PW-1:0]     mult_p;
    logic              busy;
    logic              done;
    logic [PW:0]       err_count;
    logic [4*OPW-1:0]  err_sum;
    logic [PW-1:0]     max_err;
    logic [OPW-1:0]    max_a;
    logic [OPW-1:0]    max_b;

    int unsigned       mode;
    logic [PW-1:0]     tab [NP];
    int                n_assert = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    mult_error_sweep #(.OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .err_sum   (err_sum),
        .max_err   (max_err),
        .max_a     (max_a),
        .max_b     (max_b)
    );

    // Multiplier under test: 0 exact, 1 LSB flipped, 2 one pair returns 0, 3 table.
    function automatic logic [PW-1:0] ref_prod(input int unsigned m, input int unsigned a,
                                               input int unsigned b);
        logic [PW-1:0] ex;
        ex = PW'(a * b);
        case (m)
            0:       return ex;
            1:       return ex ^ PW'(1);
            2:       return ((a == BAD_A) && (b == BAD_B)) ? '0 : ex;
            default: return tab[b * NOP + a];
        endcase
    endfunction

    always_comb begin
        mult_p = ref_prod(mode, int'(mult_a), int'(mult_b));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string pfx);
        longint unsigned e_cnt, e_sum, e_max, d, ex, p;
        int unsigned e_a, e_b;
        e_cnt = 0; e_sum = 0; e_max = 0; e_a = 0; e_b = 0;
        for (int unsigned b = 0; b < NOP; b++) begin
            for (int unsigned a = 0; a < NOP; a++) begin
                ex = longint'(a * b);
                p  = longint'(ref_prod(mode, a, b));
                d  = (p > ex) ? p - ex : ex - p;
                if (d != 0) e_cnt++;
                e_sum += d;
                if (d > e_max) begin
                    e_max = d; e_a = a; e_b = b;
                end
            end
        end
        check({pfx, "_err_count"}, 64'(err_count), e_cnt);
        check({pfx, "_err_sum"},   64'(err_sum),   e_sum);
        check({pfx, "_max_err"},   64'(max_err),   e_max);
        check({pfx, "_max_a"},     64'(max_a),     64'(e_a));
        check({pfx, "_max_b"},     64'(max_b),     64'(e_b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input string pfx, input int unsigned pulse_at);
        int unsigned c;
        bit got;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({pfx, "_start_busy"},  64'(busy),      64'd1);
        check({pfx, "_start_done"},  64'(done),      64'd0);
        check({pfx, "_start_a"},     64'(mult_a),    64'd0);
        check({pfx, "_start_cleared"}, 64'(err_count), 64'd0);
        c = 0;
        got = 1'b0;
        while ((c < 2 * N_DONE) && !got) begin
            if ((pulse_at != 0) && (c == pulse_at)) start = 1'b1;
            tick();
            start = 1'b0;
            c++;
            if (done === 1'b1) got = 1'b1;
        end
        check({pfx, "_done_latency"}, 64'(c), 64'(N_DONE));
        check({pfx, "_end_busy"},     64'(busy), 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        for (int unsigned i = 0; i < NP; i++) tab[i] = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_busy",    64'(busy),      64'd0);
        check("reset_done",    64'(done),      64'd0);
        check("reset_a",       64'(mult_a),    64'd0);
        check("reset_b",       64'(mult_b),    64'd0);
        check("reset_count",   64'(err_count), 64'd0);
        check("reset_sum",     64'(err_sum),   64'd0);
        check("reset_max",     64'(max_err),   64'd0);

        // exact multiplier
        run_sweep("exact", 0);
        check_results("exact");
        repeat ($urandom_range(3, 12)) tick();
        check("hold_done", 64'(done),   64'd1);
        check("hold_a",    64'(mult_a), 64'(NOP - 1));
        check("hold_b",    64'(mult_b), 64'(NOP - 1));
        check_results("exact_hold");

        // LSB flip, then a restart from DONE must reproduce it
        mode = 1;
        run_sweep("lsb", 0);
        check_results("lsb");
        run_sweep("lsb_restart", 0);
        check_results("lsb_restart");

        // single bad pair
        mode = 2;
        repeat ($urandom_range(1, 10)) tick();
        run_sweep("onebad", 0);
        check_results("onebad");

        // reset mid-sweep, with start also high to show rst wins
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (1000) tick();
        check("abort_pre_busy", 64'(busy), 64'd1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("abort_busy",  64'(busy),      64'd0);
        check("abort_done",  64'(done),      64'd0);
        check("abort_count", 64'(err_count), 64'd0);
        check("abort_sum",   64'(err_sum),   64'd0);
        check("abort_max",   64'(max_err),   64'd0);
        check("abort_max_a", 64'(max_a),     64'd0);
        tick();
        check("abort_idle_busy", 64'(busy), 64'd0);
        mode = 0;
        run_sweep("after_abort", 0);
        check_results("after_abort");

        // start during sweep is ignored
        mode = 1;
        run_sweep("midstart", 500);
        check_results("midstart");

        // randomly corrupted product table
        for (int unsigned b = 0; b < NOP; b++) begin
            for (int unsigned a = 0; a < NOP; a++) begin
                tab[b * NOP + a] = PW'(a * b);
                if ($urandom_range(0, 15) == 0) tab[b * NOP + a] = PW'($urandom);
            end
        end
        mode = 3;
        repeat ($urandom_range(1, 20)) tick();
        run_sweep("table", 0);
        check_results("table");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
